// File: rtl/dnn_cfg_pkg.sv
// Shared types and constants for the DNN layer-descriptor loader.
// Descriptor word layout, FSM state encoding and the descriptor sanity check.
package dnn_cfg_pkg;

  localparam int ADDR_W     = 32;
  localparam int DESC_WORDS = 13;
  localparam int IDX_W      = 4;

  localparam logic [IDX_W-1:0] IDX_FLAGS   = 4'd0;
  localparam logic [IDX_W-1:0] IDX_N       = 4'd1;
  localparam logic [IDX_W-1:0] IDX_C       = 4'd2;
  localparam logic [IDX_W-1:0] IDX_H       = 4'd3;
  localparam logic [IDX_W-1:0] IDX_W_DIM   = 4'd4;
  localparam logic [IDX_W-1:0] IDX_R       = 4'd5;
  localparam logic [IDX_W-1:0] IDX_S       = 4'd6;
  localparam logic [IDX_W-1:0] IDX_M       = 4'd7;
  localparam logic [IDX_W-1:0] IDX_P       = 4'd8;
  localparam logic [IDX_W-1:0] IDX_Q       = 4'd9;
  localparam logic [IDX_W-1:0] IDX_IN_OFF  = 4'd10;
  localparam logic [IDX_W-1:0] IDX_WT_OFF  = 4'd11;
  localparam logic [IDX_W-1:0] IDX_OUT_OFF = 4'd12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // A descriptor is rejected if any mandatory dimension is zero, or if a
  // convolution window is empty or larger than the input plane.
  function automatic logic desc_reject(
    input logic        conv,
    input logic [31:0] n, c, h, w, r, s, m, p, q
  );
    logic dims_zero;
    logic win_bad;
    dims_zero = (n == '0) || (c == '0) || (m == '0) || (p == '0) || (q == '0);
    win_bad   = conv && ((r == '0) || (s == '0) || (r > h) || (s > w));
    return dims_zero || win_bad;
  endfunction

endpackage

// File: rtl/dnn_cfg_loader_if.sv
// Bus bundle between the PCPI decoder, descriptor memory, accelerator core
// and the configuration loader.
interface dnn_cfg_loader_if #(
  parameter int ADDR_W = 32
);
  // Handshakes: a requester raises valid with stable address/data and holds
  // both until the responder's ready is sampled high on a rising clock edge;
  // the transfer completes on that edge and ready outside a request is ignored.
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_desc_addr;
  logic              cmd_wait;
  logic              cmd_ready;
  logic              cmd_err;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  logic              acc_valid;
  logic              acc_ready;

  logic              cfg_conv;
  logic [31:0]       cfg_n, cfg_c, cfg_h, cfg_w, cfg_r, cfg_s, cfg_m, cfg_p, cfg_q;
  logic [31:0]       cfg_in_off, cfg_wt_off, cfg_out_off;

  modport slave (
    input  cmd_valid, cmd_desc_addr, mem_rdata, mem_ready, acc_ready,
    output cmd_wait, cmd_ready, cmd_err, mem_valid, mem_addr, acc_valid,
    output cfg_conv, cfg_n, cfg_c, cfg_h, cfg_w, cfg_r, cfg_s, cfg_m, cfg_p, cfg_q,
    output cfg_in_off, cfg_wt_off, cfg_out_off
  );

  modport master (
    output cmd_valid, cmd_desc_addr, mem_rdata, mem_ready, acc_ready,
    input  cmd_wait, cmd_ready, cmd_err, mem_valid, mem_addr, acc_valid,
    input  cfg_conv, cfg_n, cfg_c, cfg_h, cfg_w, cfg_r, cfg_s, cfg_m, cfg_p, cfg_q,
    input  cfg_in_off, cfg_wt_off, cfg_out_off
  );
endinterface

// File: rtl/dnn_desc_regs.sv
// Layer descriptor register file: one indexed write port, every word
// exposed as a named field.
module dnn_desc_regs
  import dnn_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_flags,
  output logic [31:0]      o_n,
  output logic [31:0]      o_c,
  output logic [31:0]      o_h,
  output logic [31:0]      o_w,
  output logic [31:0]      o_r,
  output logic [31:0]      o_s,
  output logic [31:0]      o_m,
  output logic [31:0]      o_p,
  output logic [31:0]      o_q,
  output logic [31:0]      o_in_off,
  output logic [31:0]      o_wt_off,
  output logic [31:0]      o_out_off
);

  logic [31:0] r_words [DESC_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DESC_WORDS; k++) r_words[k] <= '0;
    end else if (i_we && (i_idx <= IDX_OUT_OFF)) begin
      r_words[i_idx] <= i_wdata;
    end
  end

  assign o_flags   = r_words[IDX_FLAGS];
  assign o_n       = r_words[IDX_N];
  assign o_c       = r_words[IDX_C];
  assign o_h       = r_words[IDX_H];
  assign o_w       = r_words[IDX_W_DIM];
  assign o_r       = r_words[IDX_R];
  assign o_s       = r_words[IDX_S];
  assign o_m       = r_words[IDX_M];
  assign o_p       = r_words[IDX_P];
  assign o_q       = r_words[IDX_Q];
  assign o_in_off  = r_words[IDX_IN_OFF];
  assign o_wt_off  = r_words[IDX_WT_OFF];
  assign o_out_off = r_words[IDX_OUT_OFF];

endmodule

// File: rtl/dnn_cfg_loader.sv
// DNN custom-instruction front end: fetches a 13-word layer descriptor,
// validates it, runs the accelerator core and completes the PCPI handshake.
module dnn_cfg_loader
  import dnn_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dnn_cfg_loader_if.slave   bus,
  output state_t            o_state
);

  state_t             r_state;
  logic               r_armed;
  logic [IDX_W-1:0]   r_idx;
  logic               r_cmd_wait;
  logic               r_cmd_ready;
  logic               r_cmd_err;
  logic               r_mem_valid;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_acc_valid;

  logic               w_we;
  logic               w_reject;
  logic               w_unused_flags;
  logic [31:0]        w_flags, w_n, w_c, w_h, w_w, w_r, w_s, w_m, w_p, w_q;
  logic [31:0]        w_in_off, w_wt_off, w_out_off;

  assign w_we = (r_state == FETCH) && bus.mem_ready;

  dnn_desc_regs u_regs (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_idx     (r_idx),
    .i_wdata   (bus.mem_rdata),
    .o_flags   (w_flags),
    .o_n       (w_n),
    .o_c       (w_c),
    .o_h       (w_h),
    .o_w       (w_w),
    .o_r       (w_r),
    .o_s       (w_s),
    .o_m       (w_m),
    .o_p       (w_p),
    .o_q       (w_q),
    .o_in_off  (w_in_off),
    .o_wt_off  (w_wt_off),
    .o_out_off (w_out_off)
  );

  // Only bit 0 of the flags word carries meaning today.
  assign w_unused_flags = ^w_flags[31:1];

  assign w_reject = desc_reject(w_flags[0], w_n, w_c, w_h, w_w, w_r, w_s, w_m, w_p, w_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_armed     <= 1'b1;
      r_idx       <= '0;
      r_cmd_wait  <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_acc_valid <= 1'b0;
    end else begin
      r_cmd_ready <= 1'b0;
      // A held cmd_valid must drop once before the next instruction is taken.
      if (!bus.cmd_valid) r_armed <= 1'b1;

      case (r_state)
        IDLE: begin
          if (bus.cmd_valid && r_armed) begin
            r_state     <= FETCH;
            r_idx       <= '0;
            r_mem_addr  <= bus.cmd_desc_addr;
            r_mem_valid <= 1'b1;
            r_cmd_wait  <= 1'b1;
            r_cmd_err   <= 1'b0;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            r_idx      <= r_idx + 4'd1;
            r_mem_addr <= r_mem_addr + 32'd4;
            if (r_idx == IDX_OUT_OFF) begin
              r_mem_valid <= 1'b0;
              r_state     <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_reject) begin
            r_state     <= DONE;
            r_cmd_ready <= 1'b1;
            r_cmd_err   <= 1'b1;
            r_cmd_wait  <= 1'b0;
          end else begin
            r_state     <= RUN;
            r_acc_valid <= 1'b1;
          end
        end
        RUN: begin
          if (bus.acc_ready) begin
            r_acc_valid <= 1'b0;
            r_state     <= DONE;
            r_cmd_ready <= 1'b1;
            r_cmd_err   <= 1'b0;
            r_cmd_wait  <= 1'b0;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_armed   <= 1'b0;
          r_cmd_err <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state          = r_state;
  assign bus.cmd_wait     = r_cmd_wait;
  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.cmd_err      = r_cmd_err;
  assign bus.mem_valid    = r_mem_valid;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.acc_valid    = r_acc_valid;
  assign bus.cfg_conv     = w_flags[0];
  assign bus.cfg_n        = w_n;
  assign bus.cfg_c        = w_c;
  assign bus.cfg_h        = w_h;
  assign bus.cfg_w        = w_w;
  assign bus.cfg_r        = w_r;
  assign bus.cfg_s        = w_s;
  assign bus.cfg_m        = w_m;
  assign bus.cfg_p        = w_p;
  assign bus.cfg_q        = w_q;
  assign bus.cfg_in_off   = w_in_off;
  assign bus.cfg_wt_off   = w_wt_off;
  assign bus.cfg_out_off  = w_out_off;

endmodule

// File: tb/tb_dnn_cfg_loader.sv
// Directed bench for dnn_cfg_loader: nominal, stalled memory, rejects,
// reset mid-fetch with address wrap, and held cmd_valid.
module tb_dnn_cfg_loader;
  import dnn_cfg_pkg::*;

  typedef logic [31:0] desc_t [DESC_WORDS];

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  always #5 clk = ~clk;

  dnn_cfg_loader_if bus ();

  dnn_cfg_loader dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int mem_mode  = 0;
  int stall_cnt = 0;
  logic [31:0] mem [logic [31:0]];

  desc_t nom   = '{32'd1, 32'd1, 32'd3, 32'd8, 32'd8, 32'd3, 32'd3, 32'd4, 32'd6, 32'd6,
                   32'h2000, 32'h3000, 32'h4000};
  desc_t rej_m = '{32'd1, 32'd1, 32'd3, 32'd8, 32'd8, 32'd3, 32'd3, 32'd0, 32'd6, 32'd6,
                   32'h2100, 32'h3100, 32'h4100};
  desc_t rej_r = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd8, 32'd5, 32'd3, 32'd4, 32'd6, 32'd6,
                   32'h2200, 32'h3200, 32'h4200};
  desc_t edge_ok = '{32'd1, 32'd1, 32'd3, 32'd3, 32'd2, 32'd3, 32'd2, 32'd4, 32'd6, 32'd6,
                     32'h2300, 32'h3300, 32'h4300};
  desc_t wrap  = '{32'd0, 32'd2, 32'd4, 32'd5, 32'd6, 32'd0, 32'd0, 32'd7, 32'd8, 32'd9,
                   32'hA, 32'hB, 32'hC};
  desc_t zero  = '{default: 32'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    total++;
    assert (dbg_state === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp);
    end
  endtask

  // Advance one clock and present the memory response for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    stall_cnt++;
    bus.mem_ready = (mem_mode == 0) ? 1'b1 : ((stall_cnt % 3) == 0);
    bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
  endtask

  task automatic load_desc(input logic [31:0] base, input desc_t d);
    for (int k = 0; k < DESC_WORDS; k++) mem[base + 32'(4 * k)] = d[k];
  endtask

  task automatic chk_cfg(input string tag, input desc_t d);
    logic [31:0] f;
    f = d[0];
    chk_b({tag, ".conv"}, bus.cfg_conv, f[0]);
    chk({tag, ".n"},       bus.cfg_n,       d[1]);
    chk({tag, ".c"},       bus.cfg_c,       d[2]);
    chk({tag, ".h"},       bus.cfg_h,       d[3]);
    chk({tag, ".w"},       bus.cfg_w,       d[4]);
    chk({tag, ".r"},       bus.cfg_r,       d[5]);
    chk({tag, ".s"},       bus.cfg_s,       d[6]);
    chk({tag, ".m"},       bus.cfg_m,       d[7]);
    chk({tag, ".p"},       bus.cfg_p,       d[8]);
    chk({tag, ".q"},       bus.cfg_q,       d[9]);
    chk({tag, ".in_off"},  bus.cfg_in_off,  d[10]);
    chk({tag, ".wt_off"},  bus.cfg_wt_off,  d[11]);
    chk({tag, ".out_off"}, bus.cfg_out_off, d[12]);
  endtask

  // One full command with mem_ready always high. Accepted commands get
  // acc_ready in cycle 15+delay; rejected ones must finish in cycle 15.
  task automatic run_cmd(input string tag, input logic [31:0] base, input bit exp_err,
                         input int delay, input bit hold);
    int ack;
    int last;
    ack  = 15 + delay;
    last = exp_err ? 16 : ack + 2;
    bus.cmd_desc_addr = base;
    bus.cmd_valid     = 1'b1;
    for (int c = 1; c <= last; c++) begin
      step();
      if (c == 1 && !hold) bus.cmd_valid = 1'b0;
      if (c <= 13) begin
        chk($sformatf("%s.addr%0d", tag, c), bus.mem_addr, base + 32'(4 * (c - 1)));
        chk_b($sformatf("%s.mvalid%0d", tag, c), bus.mem_valid, 1'b1);
        chk_b($sformatf("%s.wait%0d", tag, c), bus.cmd_wait, 1'b1);
      end else if (c == 14) begin
        chk_st({tag, ".check_state"}, CHECK);
        chk_b({tag, ".mvalid14"}, bus.mem_valid, 1'b0);
        chk_b({tag, ".avalid14"}, bus.acc_valid, 1'b0);
        chk_b({tag, ".ready14"}, bus.cmd_ready, 1'b0);
      end else if (exp_err) begin
        if (c == 15) begin
          chk_b({tag, ".ready15"}, bus.cmd_ready, 1'b1);
          chk_b({tag, ".err15"}, bus.cmd_err, 1'b1);
          chk_b({tag, ".wait15"}, bus.cmd_wait, 1'b0);
          chk_b({tag, ".avalid15"}, bus.acc_valid, 1'b0);
        end else begin
          chk_st({tag, ".idle"}, IDLE);
          chk_b({tag, ".ready_pulse"}, bus.cmd_ready, 1'b0);
          chk_b({tag, ".avalid_after"}, bus.acc_valid, 1'b0);
        end
      end else if (c <= ack) begin
        chk_b($sformatf("%s.avalid%0d", tag, c), bus.acc_valid, 1'b1);
        chk_b($sformatf("%s.wait%0d", tag, c), bus.cmd_wait, 1'b1);
        chk_b($sformatf("%s.ready%0d", tag, c), bus.cmd_ready, 1'b0);
        if (c == ack) bus.acc_ready = 1'b1;
      end else if (c == ack + 1) begin
        bus.acc_ready = 1'b0;
        chk_b({tag, ".done_ready"}, bus.cmd_ready, 1'b1);
        chk_b({tag, ".done_err"}, bus.cmd_err, 1'b0);
        chk_b({tag, ".done_wait"}, bus.cmd_wait, 1'b0);
        chk_b({tag, ".done_avalid"}, bus.acc_valid, 1'b0);
      end else begin
        chk_st({tag, ".idle"}, IDLE);
        chk_b({tag, ".ready_pulse"}, bus.cmd_ready, 1'b0);
      end
    end
  endtask

  initial begin
    int  nreads;
    bit  done;
    bit  prev_stall;
    logic [31:0] prev_addr;

    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_desc_addr = '0;
    bus.mem_rdata     = '0;
    bus.mem_ready     = 1'b1;
    bus.acc_ready     = 1'b0;
    load_desc(32'h0000_1000, nom);
    load_desc(32'h0000_2000, rej_m);
    load_desc(32'h0000_3000, rej_r);
    load_desc(32'h0000_5000, nom);
    load_desc(32'h0000_6000, edge_ok);
    load_desc(32'hFFFF_FFF0, wrap);

    // Reset state and quiet idle
    repeat (3) step();
    chk_st("rst.state", IDLE);
    chk_b("rst.mvalid", bus.mem_valid, 1'b0);
    chk_b("rst.wait", bus.cmd_wait, 1'b0);
    chk_b("rst.ready", bus.cmd_ready, 1'b0);
    chk_b("rst.avalid", bus.acc_valid, 1'b0);
    chk_cfg("rst.cfg", zero);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_b("idle.mvalid", bus.mem_valid, 1'b0);
      chk_st("idle.state", IDLE);
    end

    run_cmd("nom", 32'h0000_1000, 1'b0, 25, 1'b0);
    chk_cfg("nom.cfg", nom);
    repeat (2) step();

    run_cmd("rej_m", 32'h0000_2000, 1'b1, 0, 1'b0);
    chk_cfg("rej_m.cfg", rej_m);
    repeat (2) step();

    run_cmd("rej_r", 32'h0000_3000, 1'b1, 0, 1'b0);
    chk_cfg("rej_r.cfg", rej_r);
    repeat (2) step();

    run_cmd("edge", 32'h0000_6000, 1'b0, 2, 1'b0);
    chk_cfg("edge.cfg", edge_ok);
    repeat (2) step();

    // Stalled memory: mem_ready every third cycle
    mem_mode  = 1;
    stall_cnt = 0;
    nreads    = 0;
    done      = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    bus.cmd_desc_addr = 32'h0000_1000;
    bus.cmd_valid     = 1'b1;
    for (int c = 1; c <= 200 && !done; c++) begin
      step();
      if (c == 1) bus.cmd_valid = 1'b0;
      if (prev_stall) chk("stall.hold", bus.mem_addr, prev_addr);
      prev_stall = bus.mem_valid && !bus.mem_ready;
      prev_addr  = bus.mem_addr;
      if (bus.mem_valid && bus.mem_ready) begin
        chk("stall.addr", bus.mem_addr, 32'h0000_1000 + 32'(4 * nreads));
        nreads++;
      end
      if (bus.acc_valid) bus.acc_ready = 1'b1;
      if (bus.cmd_ready) begin
        chk_b("stall.err", bus.cmd_err, 1'b0);
        done = 1'b1;
      end
    end
    bus.acc_ready = 1'b0;
    mem_mode = 0;
    chk_b("stall.done", done, 1'b1);
    chk("stall.reads", 32'(nreads), 32'd13);
    chk_cfg("stall.cfg", nom);
    repeat (2) step();

    // Reset mid-FETCH after 5 words, then wrap-around fetch
    bus.cmd_desc_addr = 32'h0000_5000;
    bus.cmd_valid     = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) bus.cmd_valid = 1'b0;
    end
    chk_st("midrst.pre_state", FETCH);
    chk("midrst.pre_n", bus.cfg_n, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk_st("midrst.state", IDLE);
    chk_b("midrst.mvalid", bus.mem_valid, 1'b0);
    chk("midrst.maddr", bus.mem_addr, 32'h0);
    chk_b("midrst.wait", bus.cmd_wait, 1'b0);
    chk_b("midrst.ready", bus.cmd_ready, 1'b0);
    chk_b("midrst.err", bus.cmd_err, 1'b0);
    chk_b("midrst.avalid", bus.acc_valid, 1'b0);
    chk_cfg("midrst.cfg", zero);
    #1 rst = 1'b0;
    run_cmd("wrap", 32'hFFFF_FFF0, 1'b0, 0, 1'b0);
    chk_cfg("wrap.cfg", wrap);
    repeat (2) step();

    // Held cmd_valid: no re-accept until it drops for a cycle
    run_cmd("held", 32'h0000_1000, 1'b0, 3, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk_b("held.mvalid", bus.mem_valid, 1'b0);
      chk_st("held.state", IDLE);
    end
    bus.cmd_valid = 1'b0;
    step();
    run_cmd("refetch", 32'h0000_1000, 1'b0, 0, 1'b0);
    chk_cfg("refetch.cfg", nom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dnn_cfg_loader.md
# dnn_cfg_loader

Front-end for the DNN accelerator in the PCPI path. When the decoded DNN custom instruction arrives, the block fetches a 13-word layer descriptor from memory at the address in rs1. It latches the descriptor into configuration registers that drive the accelerator core's shape/offset inputs (conv, N..Q, input/weight/output offsets). It then starts the core, waits for completion and returns the PCPI wait/ready handshake.

## Interface
- ADDR_W, 32: memory address width
- DESC_WORDS, 13: descriptor length in words (fixed layout; not meant to be overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  decoded DNN instruction valid (pcpi_valid && opcode/funct7 match)
- cmd_desc_addr  in  32  descriptor base byte address (rs1), sampled at accept
- cmd_wait  out  1  high from accept until the cycle cmd_ready pulses
- cmd_ready  out  1  one-cycle completion pulse
- cmd_err  out  1  valid with cmd_ready; 1 = descriptor rejected, core not started
- mem_valid  out  1  descriptor read request
- mem_addr  out  32  read byte address
- mem_rdata  in  32  read data, valid when mem_ready
- mem_ready  in  1  read completes this cycle
- acc_valid  out  1  start request to accelerator core
- acc_ready  in  1  core done (Ready)
- cfg_conv  out  1  descriptor word 0 bit 0
- cfg_n, cfg_c, cfg_h, cfg_w, cfg_r, cfg_s, cfg_m, cfg_p, cfg_q  out  32 each  layer dimensions
- cfg_in_off, cfg_wt_off, cfg_out_off  out  32 each  memory base offsets

## Operation
- Descriptor word k at cmd_desc_addr + 4k (mod 2^32): 0 flags, 1 N, 2 C, 3 H, 4 W, 5 R, 6 S, 7 M, 8 P, 9 Q, 10 in_off, 11 wt_off, 12 out_off.
- FSM: IDLE -> FETCH -> CHECK -> (RUN | DONE) -> DONE -> IDLE.
- IDLE: accept when cmd_valid=1 and armed. Capture base, clear idx, go FETCH.
- Armed flag: cleared at cmd_ready; set whenever cmd_valid is sampled 0. One instruction yields exactly one command even if cmd_valid is held high.
- FETCH: mem_valid=1, mem_addr=base+4*idx. Address and valid are held until mem_ready. On mem_ready: write word idx, increment idx. After word 12 -> CHECK.
- CHECK (1 cycle): error if any of N, C, M, P, Q is 0, or if cfg_conv=1 and (R=0, S=0, R>H or S>W). Unsigned compares. Error -> DONE with err; else -> RUN.
- RUN: acc_valid=1, held until acc_ready is sampled 1, then -> DONE. acc_ready outside RUN is ignored.
- DONE (1 cycle): cmd_ready=1, cmd_err=err, cmd_wait=0 -> IDLE.
- cfg_* registers change only in FETCH; they hold the last descriptor afterwards, including through IDLE.

## Timing
- Reset (async assert): state IDLE, armed=1, all outputs 0, all cfg registers 0, idx 0. Applies mid-operation; no partial descriptor survives.
- cmd_valid sampled at edge 0 -> cmd_wait=1 and mem_valid=1 from cycle 1.
- With mem_ready always high: words are read in cycles 1..13, CHECK in cycle 14, acc_valid from cycle 15.
- acc_ready sampled high at cycle k -> cmd_ready pulse at cycle k+1; acc_valid drops at k+1.
- Error path: cmd_ready at cycle 15, acc_valid never asserted.
- Each mem_ready stall cycle adds one cycle.
- cmd_wait is 0 in the cmd_ready cycle (PCPI rule: ready implies not wait).
- No back-to-back acceptance: earliest re-accept is 2 cycles after cmd_ready, needing cmd_valid low for at least one cycle.

## Structure
- Package dnn_cfg_pkg: state enum (IDLE, FETCH, CHECK, RUN, DONE), DESC_WORDS=13, word-index constants (IDX_FLAGS..IDX_OUT_OFF).
- Sub-module dnn_desc_regs: 13x32 register file with indexed write enable, async reset to 0, and all fields exposed as outputs. The FSM, address generator and checker stay in dnn_cfg_loader.

## Test plan
- Reset: assert rst mid-cycle -> every output 0 immediately. After release, nothing happens until cmd_valid.
- Nominal conv: descriptor at 0x0000_1000 = {1, 1, 3, 8, 8, 3, 3, 4, 6, 6, 0x2000, 0x3000, 0x4000}, mem_ready always 1.
  - Expect addresses 0x1000..0x1030 in cycles 1..13 and acc_valid from cycle 15.
  - cfg outputs equal the descriptor.
  - acc_ready at cycle 40 -> cmd_ready at 41 with cmd_err=0, cmd_wait 1..40.
- Stalled memory: mem_ready high only every 3rd cycle -> mem_addr stable across stalls, 13 distinct reads, final cfg identical to the nominal case.
- Reject: descriptor with M=0 -> no acc_valid, cmd_ready at cycle 15 with cmd_err=1. Conv descriptor with R=5, H=3 -> same result.
- Reset mid-FETCH after 5 words accepted -> cfg regs 0. The next command refetches from word 0 at the new base 0xFFFF_FFF0; addresses wrap (word 4 at 0x0000_0000).
- Held cmd_valid: keep cmd_valid high for 10 cycles after cmd_ready -> no new mem_valid. Drop it for 1 cycle, raise it again -> a new fetch starts.
